// File: rtl/bus_interconnect.sv
// rtl/bus_interconnect.sv - registered base/mask bus decoder with timeout watchdog
// Optional fault statistics counter enabled by BUS_INTERCONNECT_STATS_EN.
module bus_interconnect #(
  parameter int                         NUM_SLAVES     = 5,
  parameter logic [NUM_SLAVES*32-1:0]   SLAVE_BASE     = {NUM_SLAVES{32'h0}},
  parameter logic [NUM_SLAVES*32-1:0]   SLAVE_MASK     = {NUM_SLAVES{32'hFFFFFFFF}},
  parameter int                         TIMEOUT_CYCLES = 255
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic [31:0]                m_address_in,
  input  logic                       m_read_in,
  input  logic                       m_write_in,
  input  logic [3:0]                 m_write_mask_in,
  input  logic [31:0]                m_write_value_in,
  output logic [31:0]                m_read_value_out,
  output logic                       m_ready_out,
  output logic                       m_fault_out,
  output logic [NUM_SLAVES-1:0]      s_sel_out,
  output logic [31:0]                s_address_out,
  output logic                       s_read_out,
  output logic                       s_write_out,
  output logic [3:0]                 s_write_mask_out,
  output logic [31:0]                s_write_value_out,
  input  logic [NUM_SLAVES*32-1:0]   s_read_value_in,
  input  logic [NUM_SLAVES-1:0]      s_ready_in,
  output logic [15:0]                fault_count_out
);

  localparam int IW = (NUM_SLAVES > 1) ? $clog2(NUM_SLAVES) : 1;
  localparam int CW = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

  state_t                 state_q;
  logic [31:0]            addr_q, wdata_q, rdata_q;
  logic                   rd_q, wr_q, ready_q, fault_q;
  logic [3:0]             mask_q;
  logic [IW-1:0]          idx_q;
  logic [NUM_SLAVES-1:0]  sel_q;
  logic [CW-1:0]          cnt_q;

  logic                   dec_hit;
  logic [IW-1:0]          dec_idx;
  logic                   slv_ready;
  logic [31:0]            slv_rdata;
  logic                   timeout_hit;

  // Scan downwards so the lowest matching index is the last one written.
  always_comb begin
    dec_hit = 1'b0;
    dec_idx = '0;
    for (int i = NUM_SLAVES - 1; i >= 0; i--) begin
      if ((m_address_in & SLAVE_MASK[32*i +: 32]) == SLAVE_BASE[32*i +: 32]) begin
        dec_hit = 1'b1;
        dec_idx = IW'(i);
      end
    end
  end

  always_comb begin
    slv_ready = 1'b0;
    slv_rdata = '0;
    for (int i = 0; i < NUM_SLAVES; i++) begin
      if (idx_q == IW'(i)) begin
        slv_ready = s_ready_in[i];
        slv_rdata = s_read_value_in[32*i +: 32];
      end
    end
  end

  assign timeout_hit = (TIMEOUT_CYCLES != 0) && (cnt_q == CW'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      rd_q    <= 1'b0;
      wr_q    <= 1'b0;
      ready_q <= 1'b0;
      fault_q <= 1'b0;
      mask_q  <= '0;
      idx_q   <= '0;
      sel_q   <= '0;
      cnt_q   <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (m_read_in || m_write_in) begin
            addr_q  <= m_address_in;
            wdata_q <= m_write_value_in;
            rd_q    <= m_read_in;
            wr_q    <= m_write_in;
            mask_q  <= m_read_in ? 4'h0 : m_write_mask_in;
            if ((m_read_in && m_write_in) || !dec_hit) begin
              ready_q <= 1'b1;
              fault_q <= 1'b1;
              rdata_q <= '0;
              state_q <= RESP;
            end else begin
              idx_q   <= dec_idx;
              sel_q   <= NUM_SLAVES'(1) << dec_idx;
              state_q <= ACCESS;
            end
          end
        end
        ACCESS: begin
          if (slv_ready) begin
            ready_q <= 1'b1;
            fault_q <= 1'b0;
            rdata_q <= rd_q ? slv_rdata : 32'h0;
            sel_q   <= '0;
            state_q <= RESP;
          end else if (timeout_hit) begin
            ready_q <= 1'b1;
            fault_q <= 1'b1;
            rdata_q <= '0;
            sel_q   <= '0;
            state_q <= RESP;
          end else if (cnt_q != '1) begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        RESP: begin
          ready_q <= 1'b0;
          fault_q <= 1'b0;
          rdata_q <= '0;
          cnt_q   <= '0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign m_ready_out       = ready_q;
  assign m_fault_out       = fault_q;
  assign m_read_value_out  = rdata_q;
  assign s_sel_out         = sel_q;
  assign s_address_out     = addr_q;
  assign s_read_out        = rd_q;
  assign s_write_out       = wr_q;
  assign s_write_mask_out  = mask_q;
  assign s_write_value_out = wdata_q;

`ifdef BUS_INTERCONNECT_STATS_EN
  logic [15:0] fault_cnt_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      fault_cnt_q <= '0;
    end else if (state_q == RESP && fault_q && fault_cnt_q != 16'hFFFF) begin
      fault_cnt_q <= fault_cnt_q + 16'd1;
    end
  end

  assign fault_count_out = fault_cnt_q;
`else
  assign fault_count_out = 16'h0;
`endif

endmodule
